mem_bus_controller: RTL and testbench
=====================================

MEM_BUS_CONTROLLER -- requirements
Module: mem_bus_controller

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 memAddress_i  input  16  access address from mem_control.
REQ-004 memDataWrite_i  input  16  write data from mem_control.
REQ-005 memReadWrite_i  input  1  `MemRead / `MemWrite.
REQ-006 memEnable_i  input  1  access request, `Enable active.
REQ-007 memDataRead_o  output  16  read data returned to mem_control.
REQ-008 memBusy_o  output  1  access in progress; pipeline stalls while high.
REQ-009 memDone_o  output  1  one-cycle pulse, access complete, memDataRead_o valid.
REQ-010 ramAddr_o  output  18  SRAM address, {2'b00, memAddress_i}.
REQ-011 ramEN_o / ramOE_o / ramWE_o  output  1 each  SRAM chip/output/write enables, active-low.
REQ-012 dataBus_i  input  16  shared SRAM/UART data bus, sampled value.
REQ-013 dataBus_o  output  16  value driven onto shared bus.
REQ-014 dataBusDrive_o  output  1  high = top-level tristate drives dataBus_o.
REQ-015 uartRdn_o / uartWrn_o  output  1 each  UART read/write strobes, active-low.
REQ-016 uartDataReady_i, uartTbre_i, uartTsre_i  input  1 each  UART status lines.

Function
REQ-017 Decode: 16'hBF00 = UART data, 16'hBF01 = UART status, all other addresses = SRAM.
REQ-018 States: IDLE, SRAM_RD, SRAM_WR_SETUP, SRAM_WR_PULSE, SRAM_WR_HOLD, UART_RD1, UART_RD2, UART_WR, UART_WR_WAIT, DONE.
REQ-019 Request accepted only in IDLE with memEnable_i = `Enable; inputs latched at acceptance and held internally until DONE.
REQ-020 memBusy_o is high from the acceptance edge through the DONE state; it is combinationally high in IDLE whenever memEnable_i is asserted.
REQ-021 SRAM read: IDLE->SRAM_RD (ramEN=0, ramOE=0, drive=0) -> DONE, latching dataBus_i into memDataRead_o; latency 2 cycles.
REQ-022 SRAM write: SETUP (ramEN=0, drive=1, ramWE=1) -> PULSE (ramWE=0) -> HOLD (ramWE=1, drive=1) -> DONE; address and data stable through all three states.
REQ-023 UART status read: IDLE->DONE directly; memDataRead_o = {14'b0, uartDataReady_i, uartTbre_i & uartTsre_i}.
REQ-024 UART data read: RD1 (uartRdn=0, ramEN=1) -> RD2 (uartRdn=0; latch {8'b0, dataBus_i[7:0]}) -> DONE.
REQ-025 UART write: UART_WR (drive=1, uartWrn=0, one cycle) -> UART_WR_WAIT (uartWrn=1) until uartTsre_i = 1 -> DONE.
REQ-026 Writes to the status address (16'hBF01) are discarded: IDLE->DONE with no strobe.
REQ-027 DONE asserts memDone_o for exactly one cycle, then returns to IDLE; back-to-back requests are accepted in the following IDLE cycle.
REQ-028 SRAM and UART strobes are never active in the same cycle; dataBusDrive_o is 0 in every read state and in IDLE.
REQ-029 memEnable_i deassertion mid-access is ignored; the transaction completes.

Reset
REQ-030 On rst = 1, immediately: state IDLE, memDataRead_o = 0, memBusy_o = 0, memDone_o = 0, dataBusDrive_o = 0, ramEN/OE/WE = 1, uartRdn/Wrn = 1.
REQ-031 Reset asserted mid-access aborts the access; no strobe may remain active.

Structure
REQ-032 UART addresses, state encodings, and `MemRead/`MemWrite/`Enable are defined in defines.v.
REQ-033 Single module; no sub-module; the tristate buffer lives at the top level.

Verification
REQ-034 SRAM write 16'h1234 to 16'h0040, then read 16'h0040 -> ramWE low exactly 1 cycle; read returns 16'h1234 with memDone_o 2 cycles after acceptance.
REQ-035 Status read with dataReady=1, tbre=1, tsre=0 -> memDataRead_o = 16'h0002 on the DONE cycle.
REQ-036 UART write 16'h0041 to 16'hBF00 with tsre held low for 3 cycles -> uartWrn low 1 cycle; memBusy_o stays high until tsre = 1; then memDone_o.
REQ-037 UART read with bus = 16'hAB5A -> memDataRead_o = 16'h005A; uartRdn low exactly 2 cycles.
REQ-038 rst pulsed during SRAM_WR_PULSE -> ramWE = 1, drive = 0, memBusy_o = 0 with no clock edge required.
REQ-039 Two back-to-back SRAM reads -> no cycle with dataBusDrive_o = 1; each read produces exactly one memDone_o pulse.

Source files
------------

// File: rtl/mem_bus_controller_pkg.sv
// Shared constants, state encoding and address decode for the memory bus
// controller that arbitrates the shared SRAM / UART data bus.
package mem_bus_controller_pkg;

  // Memory-mapped UART registers; every other address goes to SRAM.
  localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

  // Request encodings seen on memReadWrite_i / memEnable_i.
  localparam logic MEM_READ   = 1'b0;
  localparam logic MEM_WRITE  = 1'b1;
  localparam logic MEM_ENABLE = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE          = 4'd0,
    ST_SRAM_RD       = 4'd1,
    ST_SRAM_WR_SETUP = 4'd2,
    ST_SRAM_WR_PULSE = 4'd3,
    ST_SRAM_WR_HOLD  = 4'd4,
    ST_UART_RD1      = 4'd5,
    ST_UART_RD2      = 4'd6,
    ST_UART_WR       = 4'd7,
    ST_UART_WR_WAIT  = 4'd8,
    ST_DONE          = 4'd9
  } state_t;

  typedef enum logic [1:0] {
    TGT_SRAM      = 2'd0,
    TGT_UART_DATA = 2'd1,
    TGT_UART_STAT = 2'd2
  } target_t;

  // Map an access address onto the device that services it.
  function automatic target_t decode_target(input logic [15:0] addr);
    target_t tgt;
    if (addr == UART_DATA_ADDR) begin
      tgt = TGT_UART_DATA;
    end else if (addr == UART_STAT_ADDR) begin
      tgt = TGT_UART_STAT;
    end else begin
      tgt = TGT_SRAM;
    end
    return tgt;
  endfunction

endpackage

// File: rtl/mem_bus_controller_if.sv
// Request/response bundle between mem_control (master) and the bus
// controller (slave).
//
// Handshake: memEnable_i is the request valid. The controller is ready only
// while idle; a request is taken on the rising edge where valid is high and
// the controller is idle. memBusy_o stays high from that edge until the
// completion cycle, in which memDone_o pulses for one cycle and
// memDataRead_o holds the read result. Address, data and direction are
// captured at acceptance, so the master may change or drop them afterwards.
interface mem_bus_controller_if;

  logic [15:0] memAddress_i;
  logic [15:0] memDataWrite_i;
  logic        memReadWrite_i;
  logic        memEnable_i;
  logic [15:0] memDataRead_o;
  logic        memBusy_o;
  logic        memDone_o;

  modport master (
    output memAddress_i,
    output memDataWrite_i,
    output memReadWrite_i,
    output memEnable_i,
    input  memDataRead_o,
    input  memBusy_o,
    input  memDone_o
  );

  modport slave (
    input  memAddress_i,
    input  memDataWrite_i,
    input  memReadWrite_i,
    input  memEnable_i,
    output memDataRead_o,
    output memBusy_o,
    output memDone_o
  );

endinterface

// File: rtl/mem_bus_controller.sv
// Memory bus controller: turns single mem_control requests into SRAM or UART
// bus cycles on a shared 16-bit data bus. The tristate buffer itself lives
// above this block; dataBusDrive_o tells it when to drive dataBus_o.
module mem_bus_controller
  import mem_bus_controller_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  mem_bus_controller_if.slave  bus,
  output logic [17:0]          ramAddr_o,
  output logic                 ramEN_o,
  output logic                 ramOE_o,
  output logic                 ramWE_o,
  input  logic [15:0]          dataBus_i,
  output logic [15:0]          dataBus_o,
  output logic                 dataBusDrive_o,
  output logic                 uartRdn_o,
  output logic                 uartWrn_o,
  input  logic                 uartDataReady_i,
  input  logic                 uartTbre_i,
  input  logic                 uartTsre_i,
  output state_t               dbg_state_o
);

  state_t      state_q, state_d;
  logic [15:0] addr_q,  addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;

  logic        ram_en_n;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic        drive;
  logic        uart_rd_n;
  logic        uart_wr_n;
  logic        done;

  // State and captured request registers; reset aborts any bus cycle at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state logic: pick the bus sequence at acceptance, capture read data.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.memEnable_i == MEM_ENABLE) begin
          addr_d  = bus.memAddress_i;
          wdata_d = bus.memDataWrite_i;
          case (decode_target(bus.memAddress_i))
            TGT_UART_DATA: begin
              state_d = (bus.memReadWrite_i == MEM_WRITE) ? ST_UART_WR : ST_UART_RD1;
            end
            TGT_UART_STAT: begin
              // Status is a read-only register; a write simply completes.
              state_d = ST_DONE;
              if (bus.memReadWrite_i == MEM_READ) begin
                rdata_d = {14'b0, uartDataReady_i, uartTbre_i & uartTsre_i};
              end
            end
            default: begin
              state_d = (bus.memReadWrite_i == MEM_WRITE) ? ST_SRAM_WR_SETUP : ST_SRAM_RD;
            end
          endcase
        end
      end
      ST_SRAM_RD: begin
        rdata_d = dataBus_i;
        state_d = ST_DONE;
      end
      ST_SRAM_WR_SETUP: state_d = ST_SRAM_WR_PULSE;
      ST_SRAM_WR_PULSE: state_d = ST_SRAM_WR_HOLD;
      ST_SRAM_WR_HOLD:  state_d = ST_DONE;
      ST_UART_RD1:      state_d = ST_UART_RD2;
      ST_UART_RD2: begin
        rdata_d = {8'b0, dataBus_i[7:0]};
        state_d = ST_DONE;
      end
      ST_UART_WR:       state_d = ST_UART_WR_WAIT;
      ST_UART_WR_WAIT: begin
        // Transmitter shift register empty means the byte has left.
        if (uartTsre_i) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:          state_d = ST_IDLE;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Bus strobes decoded from the registered state only, so they are glitch-free
  // with respect to the request inputs and drop as soon as reset forces IDLE.
  always_comb begin
    ram_en_n  = 1'b1;
    ram_oe_n  = 1'b1;
    ram_we_n  = 1'b1;
    drive     = 1'b0;
    uart_rd_n = 1'b1;
    uart_wr_n = 1'b1;
    done      = 1'b0;
    case (state_q)
      ST_SRAM_RD: begin
        ram_en_n = 1'b0;
        ram_oe_n = 1'b0;
      end
      ST_SRAM_WR_SETUP: begin
        ram_en_n = 1'b0;
        drive    = 1'b1;
      end
      ST_SRAM_WR_PULSE: begin
        ram_en_n = 1'b0;
        ram_we_n = 1'b0;
        drive    = 1'b1;
      end
      ST_SRAM_WR_HOLD: begin
        ram_en_n = 1'b0;
        drive    = 1'b1;
      end
      ST_UART_RD1,
      ST_UART_RD2: begin
        uart_rd_n = 1'b0;
      end
      ST_UART_WR: begin
        drive     = 1'b1;
        uart_wr_n = 1'b0;
      end
      ST_UART_WR_WAIT: begin
        // Keep the byte on the bus past the rising edge of the write strobe.
        drive = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  assign ramAddr_o      = {2'b00, addr_q};
  assign ramEN_o        = ram_en_n;
  assign ramOE_o        = ram_oe_n;
  assign ramWE_o        = ram_we_n;
  assign dataBus_o      = wdata_q;
  assign dataBusDrive_o = drive;
  assign uartRdn_o      = uart_rd_n;
  assign uartWrn_o      = uart_wr_n;
  assign dbg_state_o    = state_q;

  // Busy also covers the request cycle itself so the pipeline stalls at once;
  // reset overrides the combinational path from memEnable_i.
  assign bus.memBusy_o     = !rst && ((state_q != ST_IDLE) || (bus.memEnable_i == MEM_ENABLE));
  assign bus.memDone_o     = done;
  assign bus.memDataRead_o = rdata_q;

endmodule

// File: tb/tb_mem_bus_controller.sv
// Testbench for mem_bus_controller: directed scenarios followed by random
// transactions, with an SRAM/UART bus model and a transaction-level reference.
module tb_mem_bus_controller;
  import mem_bus_controller_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bus_controller_if bus();

  logic [17:0] ramAddr_o;
  logic        ramEN_o, ramOE_o, ramWE_o;
  logic [15:0] dataBus_i, dataBus_o;
  logic        dataBusDrive_o;
  logic        uartRdn_o, uartWrn_o;
  logic        uartDataReady_i, uartTbre_i, uartTsre_i;
  state_t      dbg_state;

  mem_bus_controller dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus.slave),
    .ramAddr_o       (ramAddr_o),
    .ramEN_o         (ramEN_o),
    .ramOE_o         (ramOE_o),
    .ramWE_o         (ramWE_o),
    .dataBus_i       (dataBus_i),
    .dataBus_o       (dataBus_o),
    .dataBusDrive_o  (dataBusDrive_o),
    .uartRdn_o       (uartRdn_o),
    .uartWrn_o       (uartWrn_o),
    .uartDataReady_i (uartDataReady_i),
    .uartTbre_i      (uartTbre_i),
    .uartTsre_i      (uartTsre_i),
    .dbg_state_o     (dbg_state)
  );

  // ---------------- bus model (SRAM + UART receiver) ----------------
  logic [15:0] sram_mem [0:65535];
  logic [15:0] uart_word;
  int          overlap_cnt = 0;

  always_comb begin
    if (dataBusDrive_o)              dataBus_i = dataBus_o;
    else if (!ramEN_o && !ramOE_o)   dataBus_i = sram_mem[ramAddr_o[15:0]];
    else if (!uartRdn_o)             dataBus_i = uart_word;
    else                             dataBus_i = 16'hFFFF;
  end

  always @(negedge clk) begin
    if (!rst && !ramEN_o && !ramWE_o) sram_mem[ramAddr_o[15:0]] <= dataBus_o;
    if (!rst && !ramEN_o && (!uartRdn_o || !uartWrn_o)) overlap_cnt <= overlap_cnt + 1;
  end

  // ---------------- scoreboard / reference ----------------
  logic [15:0] ref_mem [0:65535];
  logic [15:0] last_rdata;
  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // 0 = SRAM, 1 = UART data, 2 = UART status
  function automatic int kind_of(input logic [15:0] a);
    if (a == 16'hBF00) return 1;
    if (a == 16'hBF01) return 2;
    return 0;
  endfunction

  // ---------------- driver ----------------
  // Called just after a falling edge; returns just after a falling edge in
  // the idle cycle that follows completion.
  task automatic do_txn(input logic [15:0] addr, input logic [15:0] wdata, input bit wr,
                        input int d, input logic [15:0] ubyte,
                        input bit dr, input bit tbre, input bit tsre);
    int k, lat, exp_lat, kind;
    int we_cnt, rdn_cnt, wrn_cnt, drv_cnt, busy_drop, addr_bad;
    int exp_we, exp_rdn, exp_wrn;
    logic [15:0] tx_data, we_data, obs_rdata, exp_rdata;
    bit done_seen, is_read;

    kind    = kind_of(addr);
    is_read = !wr;
    exp_we = 0; exp_rdn = 0; exp_wrn = 0;
    if (kind == 0 && wr)       begin exp_lat = 4;     exp_we = 1; ref_mem[addr] = wdata; end
    else if (kind == 0)        begin exp_lat = 2;     last_rdata = ref_mem[addr]; end
    else if (kind == 1 && wr)  begin exp_lat = 3 + d; exp_wrn = 1; end
    else if (kind == 1)        begin exp_lat = 3;     exp_rdn = 2; last_rdata = {8'h00, ubyte[7:0]}; end
    else if (wr)               begin exp_lat = 1; end
    else                       begin exp_lat = 1;     last_rdata = {14'b0, dr, tbre & tsre}; end
    exp_q.push_back(last_rdata);

    uart_word       = ubyte;
    uartDataReady_i = dr;
    uartTbre_i      = tbre;
    uartTsre_i      = (kind == 1 && wr) ? 1'b0 : tsre;
    bus.memAddress_i   = addr;
    bus.memDataWrite_i = wdata;
    bus.memReadWrite_i = wr;
    bus.memEnable_i    = 1'b1;
    #1;
    chk("busy_on_request", bus.memBusy_o, 1);
    @(posedge clk);
    #1;
    // Request inputs become garbage after acceptance; the access must not care.
    bus.memEnable_i    = 1'b0;
    bus.memAddress_i   = 16'($urandom);
    bus.memDataWrite_i = 16'($urandom);
    bus.memReadWrite_i = 1'($urandom);

    k = 0; lat = 0; done_seen = 0;
    we_cnt = 0; rdn_cnt = 0; wrn_cnt = 0; drv_cnt = 0; busy_drop = 0; addr_bad = 0;
    tx_data = '0; we_data = '0; obs_rdata = '0;
    while (!done_seen && k < 64) begin
      @(negedge clk);
      if (!ramWE_o)  begin we_cnt++; we_data = dataBus_o; end
      if (!uartRdn_o) rdn_cnt++;
      if (!uartWrn_o) begin wrn_cnt++; tx_data = dataBus_o; end
      if (is_read && dataBusDrive_o) drv_cnt++;
      if (!bus.memBusy_o) busy_drop++;
      if (!ramEN_o && ramAddr_o !== {2'b00, addr}) addr_bad++;
      if (bus.memDone_o) begin
        done_seen = 1;
        lat       = k + 1;
        obs_rdata = bus.memDataRead_o;
      end
      if (kind == 1 && wr && k >= 1 + d) uartTsre_i = 1'b1;
      k++;
    end
    chk("done_seen", done_seen, 1);
    chk("latency", lat, exp_lat);
    exp_rdata = exp_q.pop_front();
    chk("read_data", obs_rdata, exp_rdata);
    chk("ramWE_low_cycles", we_cnt, exp_we);
    chk("uartRdn_low_cycles", rdn_cnt, exp_rdn);
    chk("uartWrn_low_cycles", wrn_cnt, exp_wrn);
    chk("busy_held", busy_drop, 0);
    if (is_read) chk("no_drive_on_read", drv_cnt, 0);
    if (kind == 0) chk("ram_addr", addr_bad, 0);
    if (kind == 0 && wr) chk("sram_wdata", we_data, wdata);
    if (kind == 1 && wr) chk("uart_tx_data", tx_data, wdata);

    @(negedge clk);
    chk("done_one_cycle", bus.memDone_o, 0);
    chk("busy_after_done", bus.memBusy_o, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [15:0] sram_pool [0:7];

  initial begin
    int kind;
    logic [15:0] a;
    sram_pool[0] = 16'h0000; sram_pool[1] = 16'h0040; sram_pool[2] = 16'hBEFF;
    sram_pool[3] = 16'hBF02; sram_pool[4] = 16'hFFFF; sram_pool[5] = 16'h1234;
    sram_pool[6] = 16'h7F7F; sram_pool[7] = 16'h0300;
    for (int i = 0; i < 65536; i++) begin
      sram_mem[i] = '0;
      ref_mem[i]  = '0;
    end
    last_rdata = '0;
    uart_word = '0;
    uartDataReady_i = 0; uartTbre_i = 0; uartTsre_i = 0;
    bus.memAddress_i = 16'h0040; bus.memDataWrite_i = 16'h5555;
    bus.memReadWrite_i = 1'b0; bus.memEnable_i = 1'b1;

    // Reset with a pending request: everything quiet, busy suppressed.
    rst = 1'b1;
    #12;
    chk("rst_busy", bus.memBusy_o, 0);
    chk("rst_done", bus.memDone_o, 0);
    chk("rst_rdata", bus.memDataRead_o, 0);
    chk("rst_drive", dataBusDrive_o, 0);
    chk("rst_ram_strobes", {ramEN_o, ramOE_o, ramWE_o}, 3'b111);
    chk("rst_uart_strobes", {uartRdn_o, uartWrn_o}, 2'b11);
    chk("rst_state", dbg_state, ST_IDLE);
    bus.memEnable_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // SRAM write then read-back at 0x0040.
    do_txn(16'h0040, 16'h1234, 1, 0, 16'h0, 0, 0, 0);
    do_txn(16'h0040, 16'h0000, 0, 0, 16'h0, 0, 0, 0);
    // Status read: data ready, transmitter not fully empty.
    do_txn(16'hBF01, 16'h0000, 0, 0, 16'h0, 1, 1, 0);
    // UART write with tsre low for three wait cycles.
    do_txn(16'hBF00, 16'h0041, 1, 3, 16'h0, 0, 1, 0);
    // UART read: only the low byte returns.
    do_txn(16'hBF00, 16'h0000, 0, 0, 16'hAB5A, 1, 0, 0);
    // Status write is discarded, read data unchanged.
    do_txn(16'hBF01, 16'hFFFF, 1, 0, 16'h0, 1, 1, 1);

    // Reset in the middle of the SRAM write pulse.
    bus.memAddress_i = 16'h0300; bus.memDataWrite_i = 16'hBEEF;
    bus.memReadWrite_i = 1'b1; bus.memEnable_i = 1'b1;
    @(posedge clk);
    #1 bus.memEnable_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pulse_reached", ramWE_o, 0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_we", ramWE_o, 1);
    chk("midrst_en", ramEN_o, 1);
    chk("midrst_drive", dataBusDrive_o, 0);
    chk("midrst_busy", bus.memBusy_o, 0);
    chk("midrst_rdata", bus.memDataRead_o, 0);
    ref_mem[16'h0300] = 16'hBEEF;  // the pulse had already been seen by the SRAM
    last_rdata = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back SRAM reads.
    do_txn(16'h0040, 16'h0000, 0, 0, 16'h0, 0, 0, 0);
    do_txn(16'h0300, 16'h0000, 0, 0, 16'h0, 0, 0, 0);

    // Random traffic.
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 5);
      if (kind < 3)       a = sram_pool[$urandom_range(0, 7)];
      else if (kind < 5)  a = 16'hBF00;
      else                a = 16'hBF01;
      do_txn(a, 16'($urandom), 1'($urandom), $urandom_range(0, 4), 16'($urandom),
             1'($urandom), 1'($urandom), 1'($urandom));
    end

    chk("strobe_overlap", overlap_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
